key_seq_ctrl: RTL
=================

KEY_SEQ_CTRL -- requirements
Module: key_seq_ctrl

Interface
REQ-001 SHALL have parameter STEPS, default 8: number of key-read steps per attempt (1..16).
REQ-002 SHALL have parameter SEQ, default 32'h5A3C_9618: packed nibble table; nibble i (bits 4i+3:4i) is the BA7..BA4 value for step i.
REQ-003 SHALL have parameter EXPECT, default 8'hA5: the required response, where bit i is the SDRD value for step i.
REQ-004 SHALL have parameter WAIT_CYC, default 2: number of address-setup cycles before each strobe (1..15).
REQ-005 SHALL have ports clk in 1 (rising-edge clock), rst in 1 (synchronous, active-high reset), start in 1 (begin sequence), sdrd in 1 (key data read back).
REQ-006 SHALL have ports busy out 1, done out 1 (one-cycle pulse), pass out 1, resp out STEPS (captured bits), key_clk out 1 (key clock strobe).
REQ-007 SHALL have ports sser out 1 (key select, active low), br_w out 1 (read/write, 1 = read), ba13 out 1, ba12 out 1, ba_lo out 4 (BA7..BA4).
REQ-008 SHALL drive every output from flops only, with no combinational path from any input.

Function
REQ-009 SHALL implement the states IDLE, SETUP, STROBE, SAMPLE and CHECK.
REQ-010 IDLE: start=1 moves to SETUP with step=0, resp=0 and pass=0; start=0 keeps IDLE.
REQ-011 SETUP: holds for WAIT_CYC cycles, driving sser=0, br_w=1, ba13=0, ba12=1 and ba_lo=SEQ nibble[step], then moves to STROBE.
REQ-012 STROBE: one cycle with key_clk=1; the address and select outputs are unchanged from SETUP.
REQ-013 SAMPLE: one cycle with key_clk=0; resp[step] is loaded from sdrd at the end of the cycle.
REQ-014 SAMPLE exit: if step==STEPS-1, go to CHECK; otherwise step increments and the state returns to SETUP.
REQ-015 Each step SHALL occupy exactly WAIT_CYC+2 cycles.
REQ-016 CHECK: one cycle with done=1; pass is set to (resp==EXPECT) and held until the next start or reset; the state then returns to IDLE.
REQ-017 In IDLE and CHECK the bus outputs SHALL be sser=1, br_w=1, ba13=0, ba12=0, ba_lo=0, key_clk=0.
REQ-018 busy SHALL be 1 in SETUP, STROBE and SAMPLE, and 0 otherwise.
REQ-019 start SHALL be ignored while busy=1 and during the CHECK cycle; a start held high from CHECK is taken on the following IDLE cycle.
REQ-020 Absent retry (REQ-025), done SHALL pulse exactly 1+STEPS*(WAIT_CYC+2) cycles after the edge that samples start.
REQ-021 resp SHALL be stable and readable from CHECK until the next accepted start.

Reset
REQ-022 When rst=1 at a clock edge, SHALL force IDLE and clear step, resp, pass, done, busy, key_clk, ba13, ba12, ba_lo and any retry count; sser and br_w go to 1.
REQ-023 A reset mid-sequence SHALL abort the sequence with no done pulse; the next start SHALL restart from step 0.
REQ-024 rst SHALL take priority over start in the same cycle.

Configuration
REQ-025 With KEY_SEQ_RETRY_EN defined: a CHECK mismatch with retry count <3 increments the count, clears resp and step, and returns to SETUP without a done pulse; done and pass are produced only on a match or on the 4th failed attempt.
REQ-026 With KEY_SEQ_RETRY_EN defined: adds output retries out 2, holding the retry count, which clears on an accepted start.
REQ-027 Without KEY_SEQ_RETRY_EN: a single attempt only, and no retries port.

Verification
REQ-028 Defaults, start pulse at edge 0, sdrd model returns bits of 8'hA5 -> done at cycle 33, pass=1, resp=8'hA5, busy high in cycles 1..32.
REQ-029 Step trace -> ba_lo sequence 8,1,6,9,C,3,A,5; each nibble held 4 cycles; key_clk high only in cycles 3,7,...,31.
REQ-030 sdrd model returns 8'hA4 (macro off) -> done at cycle 33, pass=0, resp=8'hA4.
REQ-031 rst asserted at cycle 10 mid-sequence -> next cycle IDLE, sser=1, no done pulse; restart yields done 33 cycles after the new start.
REQ-032 start held high continuously -> done at 33, the next sequence begins at 35, second done at 68.
REQ-033 KEY_SEQ_RETRY_EN, sdrd wrong on the first two attempts then correct -> single done at cycle 99, pass=1, retries=2.

Source files
------------

// File: rtl/key_seq_ctrl.sv
// key_seq_ctrl: steps the key-read bus through a nibble table and checks the response.
// Define KEY_SEQ_RETRY_EN to retry a failed response up to three more times.
module key_seq_ctrl #(
    parameter int                 STEPS    = 8,
    parameter logic [4*STEPS-1:0] SEQ      = 32'h5A3C_9618,
    parameter logic [STEPS-1:0]   EXPECT   = 8'hA5,
    parameter int                 WAIT_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdrd,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [STEPS-1:0] resp,
    output logic             key_clk,
    output logic             sser,
    output logic             br_w,
    output logic             ba13,
    output logic             ba12,
    output logic [3:0]       ba_lo
`ifdef KEY_SEQ_RETRY_EN
    ,
    output logic [1:0]       retries
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST  = SW'(STEPS - 1);
    localparam logic [3:0]    WLAST = 4'(WAIT_CYC - 1);

    logic [2:0]       state;
    logic [2:0]       state_n;
    logic [SW-1:0]    step;
    logic [SW-1:0]    step_n;
    logic [3:0]       wcnt;
    logic [STEPS-1:0] resp_n;
    logic             launch;
    logic             accept;
    logic             last;
    logic             again;
    logic             fin;
    logic             act_n;

    // An accepted start spends one idle-looking launch cycle before SETUP.
    assign accept = (state == S_IDLE) && !launch && start;
    assign last   = (step == LAST);

`ifdef KEY_SEQ_RETRY_EN
    assign again = (state == S_CHECK) && !done;
    assign fin   = (resp_n == EXPECT) || (retries == 2'd3);
`else
    assign again = 1'b0;
    assign fin   = 1'b1;
`endif

    always_comb begin
        resp_n       = resp;
        resp_n[step] = sdrd;
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        case (state)
            S_IDLE: begin
                if (launch) state_n = S_SETUP;
            end
            S_SETUP: begin
                if (wcnt == WLAST) state_n = S_STROBE;
            end
            S_STROBE: begin
                state_n = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (last) begin
                    state_n = S_CHECK;
                end else begin
                    state_n = S_SETUP;
                    step_n  = step + 1'b1;
                end
            end
            S_CHECK: begin
                state_n = again ? S_SETUP : S_IDLE;
                if (again) step_n = '0;
            end
            default: state_n = S_IDLE;
        endcase
        if (accept) step_n = '0;
    end

    assign act_n = (state_n == S_SETUP) || (state_n == S_STROBE) ||
                   (state_n == S_SAMPLE);

    // Bus outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            launch  <= 1'b0;
            step    <= '0;
            wcnt    <= '0;
            resp    <= '0;
            pass    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            key_clk <= 1'b0;
            sser    <= 1'b1;
            br_w    <= 1'b1;
            ba13    <= 1'b0;
            ba12    <= 1'b0;
            ba_lo   <= '0;
`ifdef KEY_SEQ_RETRY_EN
            retries <= '0;
`endif
        end else begin
            state  <= state_n;
            step   <= step_n;
            launch <= accept;
            done   <= 1'b0;
            if ((state_n == S_SETUP) && (state != S_SETUP)) begin
                wcnt <= '0;
            end else if (state == S_SETUP) begin
                wcnt <= wcnt + 1'b1;
            end
            if (accept) begin
                resp <= '0;
                pass <= 1'b0;
            end
            if (state == S_SAMPLE) begin
                resp <= resp_n;
                if (last) begin
                    done <= fin;
                    pass <= (resp_n == EXPECT);
                end
            end
            if (again) resp <= '0;
            busy    <= act_n;
            key_clk <= (state_n == S_STROBE);
            sser    <= !act_n;
            br_w    <= 1'b1;
            ba13    <= 1'b0;
            ba12    <= act_n;
            ba_lo   <= act_n ? SEQ[{step_n, 2'b00} +: 4] : 4'h0;
`ifdef KEY_SEQ_RETRY_EN
            if (accept) begin
                retries <= '0;
            end else if (again) begin
                retries <= retries + 1'b1;
            end
`endif
        end
    end

endmodule
